// File: rtl/mac_accumulator_if.sv
// Handshake bundle for mac_accumulator: burst control, product stream in, result stream out.
// The master side drives start/len/p/in_valid/out_ready; the slave side is the accumulator.
interface mac_accumulator_if #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [31:0]      p;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             ovf;

    modport master (
        output start, len, p, in_valid, out_ready,
        input  in_ready, out_data, out_valid, busy, ovf
    );

    modport slave (
        input  start, len, p, in_valid, out_ready,
        output in_ready, out_data, out_valid, busy, ovf
    );
endinterface

// File: rtl/mac_accumulator.sv
// Burst multiply-accumulate sink: sums len unsigned 32-bit products; MAC_ACC_SATURATE_EN clamps on overflow.
// Latency: result valid 1 cycle after the last accepted product (len=0 gives a zero result 1 cycle after start).
// Backpressure: in_ready only in ACC; result held in HOLD until out_ready, no new burst accepted meanwhile.
module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mac_accumulator_if.slave  bus
);

`ifdef MAC_ACC_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] out_data_q, out_data_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W:0]   p_ext;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic [ACC_W-1:0] acc_add;
    logic             xfer;

    assign p_ext = {{(ACC_W + 1 - 32){1'b0}}, bus.p};
    assign sum   = {1'b0, acc_q} + p_ext;
    assign carry = sum[ACC_W];
    assign xfer  = (state_q == ACC) && bus.in_valid;

    // Once a burst has saturated it stays pinned at full scale until the next start.
    always_comb begin
        acc_add = sum[ACC_W-1:0];
        if (SATURATE && (carry || ovf_q)) begin
            acc_add = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (bus.len == '0) begin
                        cnt_d      = '0;
                        out_data_d = '0;
                        state_d    = HOLD;
                    end else begin
                        cnt_d   = bus.len;
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (xfer) begin
                    acc_d = acc_add;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        out_data_d = acc_add;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // start in the handshake cycle is deliberately dropped; IDLE must see it.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_ready  = (state_q == ACC);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_data  = out_data_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: a default-width instance plus a 32-bit instance for overflow.
// Inputs are driven and outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_mac_accumulator;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    bit   done;

    mac_accumulator_if #(.ACC_W(40), .LEN_W(8)) bus ();
    mac_accumulator_if #(.ACC_W(32), .LEN_W(8)) bus32 ();

    mac_accumulator #(.ACC_W(40), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mac_accumulator #(.ACC_W(32), .LEN_W(8)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

`ifdef MAC_ACC_SATURATE_EN
    localparam logic [31:0] OVF_RESULT = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_RESULT = 32'hFFFF_FFFE;
`endif

    initial begin
        #20000;
        if (!done) begin
            n_err++;
            $error("FAIL watchdog: wait expired before sequence completed");
            $finish;
        end
    end

    initial begin
        logic [39:0] held;
        done  = 1'b0;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.len = '0; bus.p = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus32.start = 1'b0; bus32.len = '0; bus32.p = '0; bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_out_data", bus.out_data, 40'h0);
        check("rst_ovf", bus.ovf, 1'b0);

        // Burst of 3 back-to-back products, first start right after reset release
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.len = 8'd3; bus.out_ready = 1'b1;
        @(negedge clk);
        check("b1_in_ready", bus.in_ready, 1'b1);
        check("b1_busy", bus.busy, 1'b1);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.p = 32'd6;
        @(negedge clk); bus.p = 32'd20;
        @(negedge clk); bus.p = 32'd100;
        @(negedge clk);
        check("b1_out_valid", bus.out_valid, 1'b1);
        check("b1_out_data", bus.out_data, 40'd126);
        check("b1_ovf", bus.ovf, 1'b0);
        check("b1_hold_in_ready", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("b1_out_valid_drop", bus.out_valid, 1'b0);
        check("b1_idle_busy", bus.busy, 1'b0);
        check("b1_idle_keeps_data", bus.out_data, 40'd126);

        // Four max products with gaps, start/len poked mid-burst, then HOLD stalls
        bus.start = 1'b1; bus.len = 8'd4; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.p = 32'hFFFF_FFFF;
        @(negedge clk); bus.in_valid = 1'b0;
        @(negedge clk); bus.in_valid = 1'b1; bus.start = 1'b1; bus.len = 8'd1;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("b2_still_acc", bus.in_ready, 1'b1);
        check("b2_no_early_valid", bus.out_valid, 1'b0);
        @(negedge clk); bus.in_valid = 1'b1;
        @(negedge clk);
        check("b2_after_3_xfers", bus.out_valid, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk); bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2_out_valid", bus.out_valid, 1'b1);
        check("b2_out_data", bus.out_data, 40'h3_FFFF_FFFC);
        check("b2_ovf", bus.ovf, 1'b0);
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b2_hold_valid", bus.out_valid, 1'b1);
            check("b2_hold_data", bus.out_data, 40'h3_FFFF_FFFC);
        end
        bus.out_ready = 1'b1; bus.start = 1'b1; bus.len = 8'd2;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2_idle_after_hs", bus.busy, 1'b0);
        check("b2_valid_after_hs", bus.out_valid, 1'b0);
        check("b2_data_kept", bus.out_data, held);
        @(negedge clk);
        check("b2_hs_start_ignored", bus.busy, 1'b0);

        // Zero-length burst goes straight to HOLD with a zero result
        bus.out_ready = 1'b0;
        bus.start = 1'b1; bus.len = 8'd0; bus.in_valid = 1'b1; bus.p = 32'd55;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b0;
        check("z_out_valid", bus.out_valid, 1'b1);
        check("z_out_data", bus.out_data, 40'h0);
        check("z_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("z_idle", bus.busy, 1'b0);

        // Reset mid-burst, then a fresh single-product burst
        bus.start = 1'b1; bus.len = 8'd5;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.p = 32'd9;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("r_busy", bus.busy, 1'b0);
        check("r_in_ready", bus.in_ready, 1'b0);
        check("r_out_valid", bus.out_valid, 1'b0);
        check("r_out_data", bus.out_data, 40'h0);
        check("r_ovf", bus.ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.len = 8'd1; bus.out_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.p = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("r_new_valid", bus.out_valid, 1'b1);
        check("r_new_data", bus.out_data, 40'd7);
        bus.out_ready = 1'b1;
        @(negedge clk);

        // 32-bit accumulator overflow
        bus32.start = 1'b1; bus32.len = 8'd2; bus32.out_ready = 1'b0;
        @(negedge clk);
        bus32.start = 1'b0; bus32.in_valid = 1'b1; bus32.p = 32'hFFFF_FFFF;
        @(negedge clk);
        check("o_ovf_after_first", bus32.ovf, 1'b0);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        check("o_valid", bus32.out_valid, 1'b1);
        check("o_ovf", bus32.ovf, 1'b1);
        check("o_data", bus32.out_data, OVF_RESULT);
        @(negedge clk);
        check("o_ovf_sticky_hold", bus32.ovf, 1'b1);
        bus32.out_ready = 1'b1;
        @(negedge clk);
        check("o_ovf_sticky_idle", bus32.ovf, 1'b1);
        bus32.start = 1'b1; bus32.len = 8'd1;
        @(negedge clk);
        bus32.start = 1'b0; bus32.in_valid = 1'b1; bus32.p = 32'd1;
        check("o_ovf_cleared", bus32.ovf, 1'b0);
        @(negedge clk);
        bus32.in_valid = 1'b0;
        check("o_next_data", bus32.out_data, 32'd1);
        check("o_next_ovf", bus32.ovf, 1'b0);
        @(negedge clk);

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
